// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the HI/LO multiply unit.
//   - op_t    : operation encodings carried on op_i
//   - state_t : control FSM states
//   - DEFAULT_WIDTH : default operand width
package mult_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_MADD = 2'b01,
      OP_MSUB = 2'b10,
      OP_CLR  = 2'b11
   } op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/mult_hilo_unit_if.sv
// mult_hilo_unit_if: issue/readback bundle between the ALU and the HI/LO unit.
//   start_i, op_i, a_i, b_i : request from the issuer
//   busy_o, done_o          : status back to the issuer
//   hi_o, lo_o              : architectural HI/LO registers
// Modports: master = issuer (ALU), slave = mult_hilo_unit.
interface mult_hilo_unit_if
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);
   logic             start_i;
   op_t              op_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_i, op_i, a_i, b_i,
      input  busy_o, done_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, a_i, b_i,
      output busy_o, done_o, hi_o, lo_o
   );
endinterface

// File: rtl/MULTIPLIER.sv
// MULTIPLIER: combinational signed WIDTH x WIDTH multiplier array.
//   A, B      : signed operands
//   LOW, HIGH : lower/upper halves of the signed 2*WIDTH-bit product
module MULTIPLIER #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] LOW,
   output logic [WIDTH-1:0] HIGH
);
   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;

   // Sign-extended operands multiplied modulo 2^(2*WIDTH) yield the exact signed product.
   assign a_ext        = {{WIDTH{A[WIDTH-1]}}, A};
   assign b_ext        = {{WIDTH{B[WIDTH-1]}}, B};
   assign {HIGH, LOW}  = a_ext * b_ext;
endmodule

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: multi-cycle multiply / multiply-accumulate / multiply-subtract
// into architectural HI/LO registers.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of mult_hilo_unit_if (start_i/op_i/a_i/b_i in,
//          busy_o/done_o/hi_o/lo_o out)
// Operands are latched into opa/opb on start and held for the whole BUSY
// window, so the multiplier array is a MUL_CYCLES multicycle path into HI/LO.
module mult_hilo_unit
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter int unsigned MUL_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   mult_hilo_unit_if.slave bus
);
   if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_cycles
      $error("MUL_CYCLES must be in 1..15");
   end

   // Counter starts at MUL_CYCLES-1 so the commit lands on the MUL_CYCLES-th edge.
   localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

   state_t             state;
   logic [3:0]         cnt;
   logic [WIDTH-1:0]   opa;
   logic [WIDTH-1:0]   opb;
   op_t                opr;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               done;
   logic [WIDTH-1:0]   prod_lo;
   logic [WIDTH-1:0]   prod_hi;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] hilo_nxt;

   MULTIPLIER #(.WIDTH(WIDTH)) u_mult (
      .A    (opa),
      .B    (opb),
      .LOW  (prod_lo),
      .HIGH (prod_hi)
   );

   assign prod = {prod_hi, prod_lo};

   always_comb begin
      hilo_nxt = prod;
      case (opr)
         OP_MADD: hilo_nxt = {hi, lo} + prod;
         OP_MSUB: hilo_nxt = {hi, lo} - prod;
         default: hilo_nxt = prod;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         opa   <= '0;
         opb   <= '0;
         opr   <= OP_MUL;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start_i) begin
                  if (bus.op_i == OP_CLR) begin
                     hi   <= '0;
                     lo   <= '0;
                     done <= 1'b1;
                  end else begin
                     opa   <= bus.a_i;
                     opb   <= bus.b_i;
                     opr   <= bus.op_i;
                     cnt   <= CNT_INIT;
                     state <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  {hi, lo} <= hilo_nxt;
                  done     <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy_o = (state == ST_BUSY);
   assign bus.done_o = done;
   assign bus.hi_o   = hi;
   assign bus.lo_o   = lo;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb_mult_hilo_unit: scoreboard bench for mult_hilo_unit.
// Stimulus pushes expected {HI,LO} and expected busy/done timing into a queue;
// a negedge monitor pops on the expected done cycle and compares.
// A second instance built with MUL_CYCLES=1 gets a short directed check.
module tb_mult_hilo_unit;
   import mult_pkg::*;

   localparam int unsigned W  = 32;
   localparam int          MC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mult_hilo_unit_if #(.WIDTH(W)) bus0 ();
   mult_hilo_unit_if #(.WIDTH(W)) bus1 ();

   mult_hilo_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   mult_hilo_unit #(.WIDTH(W), .MUL_CYCLES(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   typedef struct {
      int          start_cyc;
      int          done_cyc;
      logic [63:0] exp;
   } item_t;

   item_t  q[$];
   int     cyc   = 0;
   int     total = 0;
   int     bad   = 0;
   longint model = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d: got=%h want=%h", name, cyc, got, want);
      end
   endtask

   // Monitor: busy window and done pulse derived from the queued timing.
   always @(negedge clk) begin
      logic  exp_busy;
      item_t it;
      exp_busy = 1'b0;
      foreach (q[i])
         if (cyc >= q[i].start_cyc && cyc < q[i].done_cyc) exp_busy = 1'b1;
      check("busy", 64'(bus0.busy_o), 64'(exp_busy));
      if (q.size() > 0 && q[0].done_cyc <= cyc) begin
         it = q.pop_front();
         check("done_pulse", 64'(bus0.done_o), 64'd1);
         check("hilo", {bus0.hi_o, bus0.lo_o}, it.exp);
      end else begin
         check("no_done", 64'(bus0.done_o), 64'd0);
      end
   end

   // Issue one request when idle; called at posedge+#1.
   task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b, input bit hold);
      int     n;
      longint p;
      item_t  it;
      n = 0;
      while (bus0.busy_o && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus0.busy_o) check("idle_timeout", 64'(bus0.busy_o), 64'd0);
      bus0.start_i = 1'b1;
      bus0.op_i    = op;
      bus0.a_i     = a;
      bus0.b_i     = b;
      p = longint'($signed(a)) * longint'($signed(b));
      case (op)
         OP_MUL:  model = p;
         OP_MADD: model = model + p;
         OP_MSUB: model = model - p;
         default: model = 0;
      endcase
      it.start_cyc = cyc + 1;
      it.done_cyc  = (op == OP_CLR) ? cyc + 1 : cyc + 1 + MC;
      it.exp       = model;
      q.push_back(it);
      @(posedge clk); #1;
      if (hold && op != OP_CLR) begin
         // Keep start_i high with junk through the commit edge; must be ignored.
         for (int i = 0; i < MC; i++) begin
            bus0.op_i = op_t'($urandom_range(0, 3));
            bus0.a_i  = $urandom;
            bus0.b_i  = $urandom;
            @(posedge clk); #1;
         end
      end
      bus0.start_i = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       pick = 32'hFFFF_FFFF;
         1:       pick = 32'h8000_0000;
         2:       pick = 32'h7FFF_FFFF;
         3:       pick = 32'($urandom_range(0, 9));
         default: pick = $urandom;
      endcase
   endfunction

   initial begin
      int n;
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus0.start_i = 1'b0; bus0.op_i = OP_MUL; bus0.a_i = '0; bus0.b_i = '0;
      bus1.start_i = 1'b0; bus1.op_i = OP_MUL; bus1.a_i = '0; bus1.b_i = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_hilo0", {bus0.hi_o, bus0.lo_o}, 64'd0);
      check("rst_done0", 64'(bus0.done_o), 64'd0);
      check("rst_hilo1", {bus1.hi_o, bus1.lo_o}, 64'd0);
      check("rst_busy1", 64'(bus1.busy_o), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // MUL_CYCLES=1 instance: 2*2
      bus1.start_i = 1'b1; bus1.op_i = OP_MUL; bus1.a_i = 32'd2; bus1.b_i = 32'd2;
      @(posedge clk); #1;
      bus1.start_i = 1'b0;
      @(negedge clk);
      check("mc1_busy", 64'(bus1.busy_o), 64'd1);
      check("mc1_nodone", 64'(bus1.done_o), 64'd0);
      @(negedge clk);
      check("mc1_done", 64'(bus1.done_o), 64'd1);
      check("mc1_hilo", {bus1.hi_o, bus1.lo_o}, 64'd4);
      check("mc1_idle", 64'(bus1.busy_o), 64'd0);
      @(negedge clk);
      check("mc1_done_fall", 64'(bus1.done_o), 64'd0);
      @(posedge clk); #1;

      // Directed sequence
      issue(OP_MUL,  32'd2,         32'hFFFF_FFFE, 1'b0);
      issue(OP_MADD, 32'd5,         32'd6,         1'b0);
      issue(OP_MSUB, 32'hFFFF_FFFB, 32'd6,         1'b0);
      issue(OP_MUL,  32'hFFFF_FFFF, 32'd1,         1'b0);
      issue(OP_MADD, 32'd1,         32'd1,         1'b0);
      issue(OP_MUL,  32'd7,         32'd9,         1'b1);
      issue(OP_MUL,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0);
      issue(OP_CLR,  32'd0,         32'd0,         1'b0);
      issue(OP_MADD, 32'd3,         32'd4,         1'b1);

      // Randomized
      for (int i = 0; i < 60; i++)
         issue(op_t'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));

      // Reset mid-BUSY aborts with no done
      issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      rst = 1'b1;
      q.delete();
      model = 0;
      @(negedge clk);
      check("midrst_hilo", {bus0.hi_o, bus0.lo_o}, 64'd0);
      check("midrst_busy", 64'(bus0.busy_o), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (MC + 2) @(posedge clk);
      #1;
      issue(OP_MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

      // Drain
      n = 0;
      while (q.size() > 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (q.size() > 0) check("drain", 64'(q.size()), 64'd0);
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
